// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the core data port and a single-port data memory.
// Stores queue in a circular FIFO and drain in non-load cycles; loads forward the youngest match.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_W - 2;

  logic [WW-1:0]     waddr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic              load;
  logic              accept;
  logic              drain;
  logic              hit;
  logic [DATA_W-1:0] fwd_data;

  // Handshake: a store (cpu_we) is taken on the rising edge unless cpu_stall is high in
  // that cycle, in which case the core holds cpu_we/cpu_addr/cpu_wdata unchanged; loads never stall.
  assign load      = cpu_re & ~cpu_we;
  assign cpu_stall = cpu_we & (count == CW'(DEPTH));
  assign accept    = cpu_we & ~cpu_stall;
  // Gated by reset so a pending store is never written during the cycle that discards it.
  assign drain     = ~reset & (count != '0) & ~load;
  assign empty     = (count == '0);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = '0;
    if (drain) begin
      mem_we    = 1'b1;
      mem_addr  = {waddr_q[head], 2'b00};
      mem_wdata = data_q[head];
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i < int'(count)) && (waddr_q[head + PW'(i)] == cpu_addr[ADDR_W-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[head + PW'(i)];
      end
    end
  end

  assign cpu_rdata = (load && hit) ? fwd_data : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + PW'(1);
      if (drain)  head <= head + PW'(1);
      count <= count + CW'(accept) - CW'(drain);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      waddr_q[tail] <= cpu_addr[ADDR_W-1:2];
      data_q[tail]  <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: a word-memory model, a store-queue reference model,
// directed scenarios and a randomized run, all compared against the model.
module tb_dmem_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        empty;

  dmem_store_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .empty(empty)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // data memory attached to the DUT, with a log of every write it receives
  logic [31:0] mem [64];
  logic [63:0] wr_log[$];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
  end

  // reference model: pending stores in program order, the memory image, expected writes
  logic [29:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] ref_mem [64];
  logic [63:0] exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  logic        e_stall, e_mem_we, e_empty;
  logic [31:0] e_mem_addr, e_mem_wdata, e_rdata;
  logic        a_stall, a_mem_we, a_empty;
  logic [31:0] a_mem_addr, a_mem_wdata, a_rdata;

  // driver: apply one request, snapshot DUT and model outputs, then advance the model past the edge
  task automatic cycle(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wd);
    logic        is_load;
    logic [29:0] ha;
    logic [31:0] hd;
    cpu_we = we; cpu_re = re; cpu_addr = addr; cpu_wdata = wd;
    #2;
    is_load     = re & ~we;
    e_stall     = we && (q_addr.size() == DEPTH);
    e_mem_we    = (q_addr.size() != 0) && !is_load;
    e_empty     = (q_addr.size() == 0);
    e_mem_addr  = addr;
    e_mem_wdata = '0;
    if (e_mem_we) begin
      ha = q_addr[0];
      hd = q_data[0];
      e_mem_addr  = {ha, 2'b00};
      e_mem_wdata = hd;
    end
    e_rdata = ref_mem[e_mem_addr[7:2]];
    if (is_load)
      for (int i = 0; i < q_addr.size(); i++)
        if (q_addr[i] == addr[31:2]) e_rdata = q_data[i];
    a_stall = cpu_stall; a_mem_we = mem_we; a_empty = empty;
    a_mem_addr = mem_addr; a_mem_wdata = mem_wdata; a_rdata = cpu_rdata;
    @(posedge clk);
    if (e_mem_we) begin
      ha = q_addr.pop_front();
      hd = q_data.pop_front();
      ref_mem[ha[5:0]] = hd;
      exp_q.push_back({ha, 2'b00, hd});
    end
    if (we && !e_stall) begin
      q_addr.push_back(addr[31:2]);
      q_data.push_back(wd);
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #2;
    n_cmp++;
    if (mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_cycle_mem_we: got %0b want 0", mem_we);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp += 3;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", a_empty); end
    if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", a_stall); end
    if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %0b want 0", a_mem_we); end
  endtask

  task automatic test_store_drain();
    cycle(1'b1, 1'b0, 32'h54, 32'h7);
    n_cmp += 2;
    if (a_stall !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %0b want 0", a_stall); end
    if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL store_same_cycle_we: got %0b want 0", a_mem_we); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp += 4;
    if (a_mem_we !== 1'b1) begin n_fail++; $display("FAIL drain_we: got %0b want 1", a_mem_we); end
    if (a_mem_addr !== 32'h54) begin n_fail++; $display("FAIL drain_addr: got %h want 00000054", a_mem_addr); end
    if (a_mem_wdata !== 32'h7) begin n_fail++; $display("FAIL drain_data: got %h want 00000007", a_mem_wdata); end
    if (a_empty !== 1'b0) begin n_fail++; $display("FAIL drain_empty_before: got %0b want 0", a_empty); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp += 2;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL drained_empty: got %0b want 1", a_empty); end
    if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL drained_we: got %0b want 0", a_mem_we); end
  endtask

  task automatic test_forward();
    cycle(1'b1, 1'b0, 32'h10, 32'hA);
    cycle(1'b0, 1'b1, 32'h10, 32'h0);
    n_cmp += 2;
    if (a_rdata !== 32'hA) begin n_fail++; $display("FAIL fwd_rdata: got %h want 0000000a", a_rdata); end
    if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL fwd_mem_we: got %0b want 0", a_mem_we); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp += 2;
    if (a_mem_we !== 1'b1) begin n_fail++; $display("FAIL fwd_drain_we: got %0b want 1", a_mem_we); end
    if (a_mem_addr !== 32'h10) begin n_fail++; $display("FAIL fwd_drain_addr: got %h want 00000010", a_mem_addr); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = wr_log.size();
    cycle(1'b1, 1'b0, 32'h20, 32'h1);
    cycle(1'b1, 1'b0, 32'h21, 32'h2);
    cycle(1'b0, 1'b1, 32'h22, 32'h0);
    n_cmp++;
    if (a_rdata !== 32'h2) begin n_fail++; $display("FAIL b2b_youngest: got %h want 00000002", a_rdata); end
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (wr_log.size() != base + 2) begin
      n_fail++; $display("FAIL b2b_write_count: got %0d want %0d", wr_log.size() - base, 2);
    end else begin
      n_cmp += 2;
      if (wr_log[base] !== {32'h20, 32'h1}) begin n_fail++; $display("FAIL b2b_first_write: got %h want %h", wr_log[base], {32'h20, 32'h1}); end
      if (wr_log[base+1] !== {32'h20, 32'h2}) begin n_fail++; $display("FAIL b2b_second_write: got %h want %h", wr_log[base+1], {32'h20, 32'h2}); end
    end
  endtask

  task automatic test_load_block();
    cycle(1'b1, 1'b0, 32'h30, 32'h33);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b1, 32'h40, 32'h0);
      n_cmp += 3;
      if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL blk_we: got %0b want 0", a_mem_we); end
      if (a_mem_addr !== 32'h40) begin n_fail++; $display("FAIL blk_addr: got %h want 00000040", a_mem_addr); end
      if (a_rdata !== e_rdata) begin n_fail++; $display("FAIL blk_rdata: got %h want %h", a_rdata, e_rdata); end
    end
    cycle(1'b0, 1'b0, 32'h0, 32'h0);
    n_cmp += 2;
    if (a_mem_we !== 1'b1) begin n_fail++; $display("FAIL blk_resume_we: got %0b want 1", a_mem_we); end
    if (a_mem_wdata !== 32'h33) begin n_fail++; $display("FAIL blk_resume_data: got %h want 00000033", a_mem_wdata); end
  endtask

  // alternating stores and loads push on occupancy; stall must follow the model throughout
  task automatic test_pressure();
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) cycle(1'b1, 1'b0, 32'h80 + 32'(k * 4), 32'(k + 100));
      else            cycle(1'b0, 1'b1, 32'h80 + 32'((k - 1) * 4), 32'h0);
      n_cmp += 3;
      if (a_stall !== e_stall) begin n_fail++; $display("FAIL press_stall: got %0b want %0b", a_stall, e_stall); end
      if (a_rdata !== e_rdata) begin n_fail++; $display("FAIL press_rdata: got %h want %h", a_rdata, e_rdata); end
      if (a_empty !== e_empty) begin n_fail++; $display("FAIL press_empty: got %0b want %0b", a_empty, e_empty); end
    end
  endtask

  task automatic test_reset_pending();
    int base;
    cycle(1'b1, 1'b0, 32'h60, 32'h66);
    base = wr_log.size();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 32'h0);
      n_cmp += 2;
      if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL rstp_we: got %0b want 0", a_mem_we); end
      if (a_empty !== 1'b1) begin n_fail++; $display("FAIL rstp_empty: got %0b want 1", a_empty); end
    end
    n_cmp++;
    if (wr_log.size() != base) begin n_fail++; $display("FAIL rstp_no_write: got %0d writes want 0", wr_log.size() - base); end
  endtask

  task automatic test_random();
    logic        we, re;
    logic [31:0] addr, wd;
    for (int k = 0; k < 400; k++) begin
      we   = ($urandom_range(0, 99) < 40);
      re   = ($urandom_range(0, 99) < 45);
      addr = 32'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      wd   = $urandom;
      cycle(we, re, addr, wd);
      n_cmp += 6;
      if (a_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall @%0d: got %0b want %0b", k, a_stall, e_stall); end
      if (a_mem_we !== e_mem_we) begin n_fail++; $display("FAIL rnd_mem_we @%0d: got %0b want %0b", k, a_mem_we, e_mem_we); end
      if (a_mem_addr !== e_mem_addr) begin n_fail++; $display("FAIL rnd_mem_addr @%0d: got %h want %h", k, a_mem_addr, e_mem_addr); end
      if (a_mem_wdata !== e_mem_wdata) begin n_fail++; $display("FAIL rnd_mem_wdata @%0d: got %h want %h", k, a_mem_wdata, e_mem_wdata); end
      if (a_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata @%0d: got %h want %h", k, a_rdata, e_rdata); end
      if (a_empty !== e_empty) begin n_fail++; $display("FAIL rnd_empty @%0d: got %0b want %0b", k, a_empty, e_empty); end
    end
    for (int k = 0; k < DEPTH + 2; k++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // scoreboard: every memory write seen against the model's expected write order
  task automatic test_write_order();
    n_cmp++;
    if (wr_log.size() != exp_q.size()) begin
      n_fail++; $display("FAIL order_count: got %0d want %0d", wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (wr_log[i] !== exp_q[i]) begin n_fail++; $display("FAIL order_entry %0d: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    reset = 1'b1;
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_store_drain();
    test_forward();
    test_back_to_back();
    test_load_block();
    test_pressure();
    test_reset_pending();
    test_random();
    test_write_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
